// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared ARM condition codes, flag indices and issue FSM states
// Purpose: common types for the conditional-issue controller.
// Contents: cond_e (EQ..AL, NV), FLAG_* bit positions within {N,Z,C,V}, state_e.
package arm_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - combinational ARM condition-code evaluator
// Purpose: decide whether an instruction's condition passes on a set of flags.
// Ports:
//   cond  [3:0] in  : condition field
//   flags [3:0] in  : {N,Z,C,V}
//   pass        out : condition satisfied (AL and NV always pass)
module cond_eval
  import arm_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b1;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c & !z;
      COND_LS: pass = !c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z & (n == v);
      COND_LE: pass = z | (n != v);
      default: pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_issue_ctrl.sv
// rtl/cond_issue_ctrl.sv - ID-to-EX issue control for conditionally executed instructions
// Purpose: holds an instruction in ID until the flags it depends on are final,
// evaluates its condition, and issues it to EX (as a bubble when the condition fails).
// Tracks in-flight flag setters, the architectural status register, stall cycles and
// an error for flag writebacks with no outstanding setter.
// Ports:
//   clk, rst (sync, active-high)
//   id_valid, id_cond[3:0], id_s, flush, ex_stall  : ID/EX control inputs
//   wb_flag_we, wb_flags[3:0]                      : flag writeback from WB
//   id_ready                                       : ID instruction accepted this cycle
//   issue_valid, issue_exec, issue_s               : registered issue to EX
//   sr[3:0], stall_cnt[STALL_CNT_W-1:0], err       : status outputs
module cond_issue_ctrl
  import arm_pkg::*;
#(
  parameter int MAX_PENDING = 3,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [3:0]             id_cond,
  input  logic                   id_s,
  output logic                   id_ready,
  input  logic                   flush,
  input  logic                   ex_stall,
  input  logic                   wb_flag_we,
  input  logic [3:0]             wb_flags,
  output logic                   issue_valid,
  output logic                   issue_exec,
  output logic                   issue_s,
  output logic [3:0]             sr,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic                   err
);

  localparam int PEND_W = $clog2(MAX_PENDING + 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

  state_e                 state_q, state_d;
  logic [PEND_W-1:0]      pending_q, pending_d;
  logic [3:0]             sr_q, sr_d;
  logic                   issue_valid_q, issue_valid_d;
  logic                   issue_exec_q, issue_exec_d;
  logic                   issue_s_q, issue_s_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic                   err_q, err_d;

  logic [3:0] eff_flags;
  logic       cond_pass;
  logic       cond_needed;
  logic       flags_ready;
  logic       setter_blocked;
  logic       fire;
  logic       pend_inc, pend_dec;
  logic       stall_inc;

  // A writeback in the same cycle is visible to the instruction in ID.
  assign eff_flags = wb_flag_we ? wb_flags : sr_q;

  cond_eval u_cond_eval (
    .cond  (id_cond),
    .flags (eff_flags),
    .pass  (cond_pass)
  );

  assign cond_needed = (id_cond != COND_AL) && (id_cond != COND_NV);

  // Flags are final once no setter is in flight, or the last one writes back now.
  assign flags_ready = (pending_q == '0) || ((pending_q == PEND_W'(1)) && wb_flag_we);

  // A new setter cannot issue into a full tracker unless one retires this cycle.
  assign setter_blocked = id_s && (pending_q == PEND_MAX) && !wb_flag_we;

  assign id_ready = id_valid && !flush && !ex_stall
                    && (!cond_needed || flags_ready) && !setter_blocked;
  assign fire     = id_valid && id_ready;

  // Only setters whose condition passes will actually write flags.
  assign pend_inc = fire && id_s && cond_pass;
  // Guard keeps a spurious writeback from wrapping the counter.
  assign pend_dec = wb_flag_we && (pending_q != '0);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (id_valid && cond_needed && !flags_ready && !flush && !ex_stall) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (fire || flush || !id_valid) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // FSM: outputs
  always_comb begin
    stall_inc = (state_q == ST_WAIT) && (stall_cnt_q != '1);
  end

  always_comb begin
    pending_d = pending_q;
    if (pend_inc && !pend_dec) begin
      pending_d = pending_q + PEND_W'(1);
    end else if (pend_dec && !pend_inc) begin
      pending_d = pending_q - PEND_W'(1);
    end

    sr_d        = wb_flag_we ? wb_flags : sr_q;
    err_d       = err_q || (wb_flag_we && (pending_q == '0));
    stall_cnt_d = stall_inc ? stall_cnt_q + STALL_CNT_W'(1) : stall_cnt_q;

    issue_valid_d = issue_valid_q;
    issue_exec_d  = issue_exec_q;
    issue_s_d     = issue_s_q;
    if (fire) begin
      issue_valid_d = 1'b1;
      issue_exec_d  = cond_pass;
      issue_s_d     = id_s && cond_pass;
    end else if (!ex_stall) begin
      issue_valid_d = 1'b0;
      issue_exec_d  = 1'b0;
      issue_s_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q     <= '0;
      sr_q          <= '0;
      err_q         <= 1'b0;
      stall_cnt_q   <= '0;
      issue_valid_q <= 1'b0;
      issue_exec_q  <= 1'b0;
      issue_s_q     <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      sr_q          <= sr_d;
      err_q         <= err_d;
      stall_cnt_q   <= stall_cnt_d;
      issue_valid_q <= issue_valid_d;
      issue_exec_q  <= issue_exec_d;
      issue_s_q     <= issue_s_d;
    end
  end

  assign issue_valid = issue_valid_q;
  assign issue_exec  = issue_exec_q;
  assign issue_s     = issue_s_q;
  assign sr          = sr_q;
  assign stall_cnt   = stall_cnt_q;
  assign err         = err_q;

endmodule
